// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock qualification sequencer in the CLKI domain.
// Optional RELOCK_CNT output enabled by defining PLL_RELOCK_COUNT_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 2500,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       CLKI,
  input  logic       RSTN,
  input  logic       LOCKED,
  input  logic       RETRY,
  output logic       PLL_RST,
  output logic       SYS_RESETN,
  output logic       READY,
  output logic       FAULT,
`ifdef PLL_RELOCK_COUNT_EN
  output logic [7:0] RELOCK_CNT,
`endif
  output logic [2:0] STATE
);

  localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT)
                          ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX   = (CMAX_A > STABLE_CYCLES)
                          ? CMAX_A : STABLE_CYCLES;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int RW     = (MAX_RETRIES > 0)
                          ? $clog2(MAX_RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [RW-1:0] retries;
  logic [RW-1:0] ret_nxt;
  logic          lock_s1;
  logic          lock_s;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    ret_nxt = retries;
    unique case (state)
      S_RESET_PLL: begin
        if (cnt == CW'(RST_CYCLES - 1))
          nxt = S_WAIT_LOCK;
        else
          cnt_nxt = cnt + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          nxt = S_STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          if (retries == RW'(MAX_RETRIES)) begin
            nxt = S_FAULT;
          end else begin
            ret_nxt = retries + 1'b1;
            nxt     = S_RESET_PLL;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          nxt = S_WAIT_LOCK;
        end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
          nxt     = S_RUN;
          ret_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s)
          nxt = S_RESET_PLL;
      end
      S_FAULT: begin
        if (RETRY) begin
          nxt     = S_RESET_PLL;
          ret_nxt = '0;
        end
      end
      default: nxt = S_RESET_PLL;
    endcase
    // every state entry starts its own count from zero
    if (nxt != state)
      cnt_nxt = '0;
  end

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_RESET_PLL;
      cnt        <= '0;
      retries    <= '0;
      lock_s1    <= 1'b0;
      lock_s     <= 1'b0;
      PLL_RST    <= 1'b1;
      SYS_RESETN <= 1'b0;
      READY      <= 1'b0;
      FAULT      <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_nxt;
      retries    <= ret_nxt;
      lock_s1    <= LOCKED;
      lock_s     <= lock_s1;
      PLL_RST    <= (nxt == S_RESET_PLL) || (nxt == S_FAULT);
      SYS_RESETN <= (nxt == S_RUN);
      READY      <= (nxt == S_RUN);
      FAULT      <= (nxt == S_FAULT);
    end
  end

  assign STATE = state;

`ifdef PLL_RELOCK_COUNT_EN
  logic [7:0] relock;

  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN)
      relock <= '0;
    else if (state == S_RUN && nxt == S_RESET_PLL
             && relock != 8'hFF)
      relock <= relock + 1'b1;
  end

  assign RELOCK_CNT = relock;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer with a PLL behaviour model.
// Build with PLL_RELOCK_COUNT_EN to also check RELOCK_CNT.
module tb_pll_lock_sequencer;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int SC = 16;
  localparam int MR = 2;

  logic       CLKI = 1'b0;
  logic       RSTN = 1'b0;
  logic       LOCKED = 1'b0;
  logic       RETRY = 1'b0;
  logic       PLL_RST;
  logic       SYS_RESETN;
  logic       READY;
  logic       FAULT;
  logic [2:0] STATE;
`ifdef PLL_RELOCK_COUNT_EN
  logic [7:0] RELOCK_CNT;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES(RC),
    .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR)
  ) dut (
    .CLKI(CLKI),
    .RSTN(RSTN),
    .LOCKED(LOCKED),
    .RETRY(RETRY),
    .PLL_RST(PLL_RST),
    .SYS_RESETN(SYS_RESETN),
    .READY(READY),
    .FAULT(FAULT),
`ifdef PLL_RELOCK_COUNT_EN
    .RELOCK_CNT(RELOCK_CNT),
`endif
    .STATE(STATE)
  );

  always #5 CLKI = ~CLKI;

  typedef struct packed {
    logic [2:0] st;
    logic       prst;
    logic       sysn;
    logic       rdy;
    logic       flt;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  // reference: phase = spec state number, t = cycles spent in phase
  int   m_ph, m_t, m_tries, m_rel;
  bit   dly[2];
  bit   p_rstn, p_lock, p_retry;
  int   pll_cnt = 0;
  int   pll_dly = 10;
  int   force_low = 0;

  function automatic void model_reset();
    m_ph = 0; m_t = 0; m_tries = 0; m_rel = 0;
    dly[0] = 0; dly[1] = 0;
  endfunction

  function automatic void model_edge();
    bit l;
    l = dly[1];
    dly[1] = dly[0];
    dly[0] = p_lock;
    case (m_ph)
      0: begin
        m_t++;
        if (m_t == RC) begin m_ph = 1; m_t = 0; end
      end
      1: begin
        if (l) begin
          m_ph = 2; m_t = 0;
        end else begin
          m_t++;
          if (m_t == LT) begin
            m_t = 0;
            if (m_tries == MR) m_ph = 4;
            else begin m_tries++; m_ph = 0; end
          end
        end
      end
      2: begin
        if (!l) begin
          m_ph = 1; m_t = 0;
        end else begin
          m_t++;
          if (m_t == SC) begin m_ph = 3; m_t = 0; m_tries = 0; end
        end
      end
      3: if (!l) begin
        m_ph = 0; m_t = 0;
        if (m_rel < 255) m_rel++;
      end
      4: if (p_retry) begin m_ph = 0; m_t = 0; m_tries = 0; end
      default: m_ph = 0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.st   = 3'(m_ph);
    e.prst = (m_ph == 0) || (m_ph == 4);
    e.sysn = (m_ph == 3);
    e.rdy  = (m_ph == 3);
    e.flt  = (m_ph == 4);
`ifdef PLL_RELOCK_COUNT_EN
    e.rc   = 8'(m_rel);
`else
    e.rc   = 8'd0;
`endif
    return e;
  endfunction

  // one CLKI cycle: account for the edge, queue the expectation, drive
  task automatic step(input bit rstn, input bit retry);
    exp_t e;
    bit   lk;
    @(posedge CLKI);
    #1;
    if (p_rstn) model_edge();
    if (!rstn) model_reset();
    e = model_out();
    q.push_back(e);
    if (e.prst) pll_cnt = 0;
    else pll_cnt++;
    lk = (pll_dly >= 0) && (pll_cnt >= pll_dly) && (force_low == 0);
    if (force_low > 0) force_low--;
    RSTN = rstn; LOCKED = lk; RETRY = retry;
    p_rstn = rstn; p_lock = lk; p_retry = retry;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  task automatic run_until(input int ph, input int t, input int budget);
    int k;
    k = 0;
    while (!(m_ph == ph && m_t >= t) && k < budget) begin
      step(1'b1, 1'b0);
      k++;
    end
    if (!(m_ph == ph && m_t >= t)) begin
      n_total++;
      $display("FAIL wait_phase: phase %0d t %0d, required phase %0d t %0d",
               m_ph, m_t, ph, t);
    end
  endtask

  initial begin : monitor
    exp_t e;
    exp_t a;
    forever begin
      @(negedge CLKI);
      if (q.size() > 0) begin
        e = q.pop_front();
        a.st = STATE; a.prst = PLL_RST; a.sysn = SYS_RESETN;
        a.rdy = READY; a.flt = FAULT;
`ifdef PLL_RELOCK_COUNT_EN
        a.rc = RELOCK_CNT;
`else
        a.rc = 8'd0;
`endif
        n_total++;
        if (a === e) n_pass++;
        else
          $display("FAIL outputs t=%0t: got st=%0d rst=%b sysn=%b rdy=%b flt=%b rc=%0d, required st=%0d rst=%b sysn=%b rdy=%b flt=%b rc=%0d",
                   $time, a.st, a.prst, a.sysn, a.rdy, a.flt, a.rc,
                   e.st, e.prst, e.sysn, e.rdy, e.flt, e.rc);
      end
    end
  end

  initial begin : stim
    int rst_hold;
    p_rstn = 0; p_lock = 0; p_retry = 0;
    model_reset();
    repeat (3) step(1'b0, 1'b0);

    // normal bring-up
    pll_dly = 10;
    run_until(3, 0, 300);
    run_n(5);

    // glitch at stable count 8, then full window again
    force_low = 2;
    run_until(2, 8, 300);
    force_low = 3;
    run_until(3, 0, 300);
    run_n(4);

    // ignored RETRY in RUN
    step(1'b1, 1'b1);
    run_n(4);

    // lock loss in RUN and relock
    force_low = 2;
    run_until(0, 0, 50);
    run_until(3, 0, 300);

    // timeouts into FAULT, then RETRY
    pll_dly = -1;
    force_low = 1;
    run_until(4, 0, 1000);
    run_n(6);
    pll_dly = 10;
    step(1'b1, 1'b1);
    run_until(3, 0, 300);

    // async reset mid-STABLE
    force_low = 1;
    run_until(2, 5, 300);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    run_until(3, 0, 300);

    // randomized traffic
    rst_hold = 0;
    for (int i = 0; i < 5000; i++) begin
      bit rn, rt;
      if (m_ph == 0 && m_t == 1) begin
        pll_dly = int'($urandom_range(0, 130));
        if (pll_dly > 110) pll_dly = -1;
      end
      if (rst_hold == 0 && $urandom_range(0, 399) == 0)
        rst_hold = int'($urandom_range(1, 3));
      if (force_low == 0 && $urandom_range(0, 59) == 0)
        force_low = int'($urandom_range(1, 5));
      rt = ($urandom_range(0, 39) == 0);
      rn = (rst_hold == 0);
      if (rst_hold > 0) rst_hold--;
      step(rn, rt);
    end

`ifdef PLL_RELOCK_COUNT_EN
    // saturate the relock counter
    pll_dly = 1;
    for (int i = 0; i < 300; i++) begin
      run_until(3, 0, 400);
      force_low = 1;
      step(1'b1, 1'b0);
    end
    run_until(3, 0, 400);
`endif

    run_n(3);
    @(negedge CLKI);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
